instr_fetch: RTL and testbench

//   Multi-cycle instruction fetch/issue unit. Sole producer of the Opcode bus read by Control.

---
 rtl/instr_fetch_if.sv | 24 ++
 rtl/instr_fetch.sv | 117 +++++++++++
 tb/tb_instr_fetch.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and its memory.
interface instr_fetch_if #(
   parameter int WIDTH_PC    = 8,
   parameter int WIDTH_INSTR = 16
);
   logic                   imemReq;
   logic [WIDTH_PC-1:0]    imemAddr;
   logic                   imemAck;
   logic [WIDTH_INSTR-1:0] imemData;

   modport master (
      output imemReq,
      output imemAddr,
      input  imemAck,
      input  imemData
   );

   modport slave (
      input  imemReq,
      input  imemAddr,
      output imemAck,
      output imemData
   );
endinterface

// File: rtl/instr_fetch.sv
// Multi-cycle fetch/issue unit: FETCH -> ISSUE -> FETCH, stops permanently on the HALT opcode.
// Define IFETCH_PERF_EN to build the saturating consumed-instruction counter on instrCount.
module instr_fetch #(
   parameter int                      WIDTH_OPCODE = 4,
   parameter int                      WIDTH_INSTR  = 16,
   parameter int                      WIDTH_PC     = 8,
   parameter logic [WIDTH_PC-1:0]     RESET_PC     = '0,
   parameter logic [WIDTH_OPCODE-1:0] HALT_OPCODE  = 4'hF
) (
   input  logic                            clk,
   input  logic                            rst_n,
   instr_fetch_if.master                   imem,
   input  logic                            stall,
   input  logic                            branchTaken,
   input  logic [WIDTH_PC-1:0]             branchTarget,
   output logic [WIDTH_OPCODE-1:0]         Opcode,
   output logic [WIDTH_INSTR-WIDTH_OPCODE-1:0] Operand,
   output logic                            instrValid,
   output logic [WIDTH_PC-1:0]             PC,
   output logic                            halted,
   output logic [15:0]                     instrCount
);

   localparam int WIDTH_OPERAND = WIDTH_INSTR - WIDTH_OPCODE;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t                    state_reg,   state_next;
   logic [WIDTH_PC-1:0]       pc_reg,      pc_next;
   logic                      req_reg,     req_next;
   logic [WIDTH_OPCODE-1:0]   opcode_reg,  opcode_next;
   logic [WIDTH_OPERAND-1:0]  operand_reg, operand_next;
   logic                      consume;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_FETCH;
         pc_reg      <= RESET_PC;
         req_reg     <= 1'b0;
         opcode_reg  <= '0;
         operand_reg <= '0;
      end else begin
         state_reg   <= state_next;
         pc_reg      <= pc_next;
         req_reg     <= req_next;
         opcode_reg  <= opcode_next;
         operand_reg <= operand_next;
      end
   end

   assign consume = (state_reg == ST_ISSUE) && !stall;

   always_comb begin
      state_next   = state_reg;
      pc_next      = pc_reg;
      opcode_next  = opcode_reg;
      operand_next = operand_reg;

      case (state_reg)
         ST_FETCH: begin
            // An ack only counts while our request is actually on the bus.
            if (req_reg && imem.imemAck) begin
               {opcode_next, operand_next} = imem.imemData;
               state_next                  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (consume) begin
               if (opcode_reg == HALT_OPCODE) begin
                  state_next = ST_HALT;
               end else begin
                  pc_next    = branchTaken ? branchTarget : pc_reg + WIDTH_PC'(1);
                  state_next = ST_FETCH;
               end
            end
         end
         ST_HALT: begin
            state_next = ST_HALT;
         end
         default: begin
            state_next = ST_FETCH;
         end
      endcase

      // Request is registered, so it comes up one cycle after reset and drops right after the ack.
      req_next = (state_next == ST_FETCH);
   end

   assign imem.imemReq  = req_reg;
   assign imem.imemAddr = pc_reg;
   assign Opcode        = opcode_reg;
   assign Operand       = operand_reg;
   assign instrValid    = (state_reg == ST_ISSUE);
   assign halted        = (state_reg == ST_HALT);
   assign PC            = pc_reg;

`ifdef IFETCH_PERF_EN
   logic [15:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= 16'h0000;
      end else if (consume && (count_reg != 16'hFFFF)) begin
         count_reg <= count_reg + 16'h0001;
      end
   end

   assign instrCount = count_reg;
`else
   assign instrCount = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model of the fetch/issue rules.
module tb_instr_fetch;

   localparam int WP = 8;
   localparam int WI = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          stall = 1'b0;
   logic          branchTaken = 1'b0;
   logic [WP-1:0] branchTarget = '0;
   logic [3:0]    Opcode;
   logic [11:0]   Operand;
   logic          instrValid;
   logic [WP-1:0] PC;
   logic          halted;
   logic [15:0]   instrCount;

   instr_fetch_if #(.WIDTH_PC(WP), .WIDTH_INSTR(WI)) bus ();

   instr_fetch dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem         (bus),
      .stall        (stall),
      .branchTaken  (branchTaken),
      .branchTarget (branchTarget),
      .Opcode       (Opcode),
      .Operand      (Operand),
      .instrValid   (instrValid),
      .PC           (PC),
      .halted       (halted),
      .instrCount   (instrCount)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [256];
   int n_checks = 0;
   int n_errors = 0;
   int ack_delay_cfg = 0;
   bit spur_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name, input int limit);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < limit; k++) begin
         if (instrValid === 1'b1) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      n_checks++;
      if (!seen) begin
         n_errors++;
         $display("FAIL %s: instrValid got 0 expected 1 within %0d cycles", name, limit);
      end
   endtask

   // Reference model: program counter, whether the current fetch has returned, halt, count.
   logic [WP-1:0] m_pc = '0;
   bit            m_fetched = 1'b0;
   bit            m_halt = 1'b0;
   bit            m_warm = 1'b0;
   logic [15:0]   m_instr = '0;
   logic [15:0]   m_count = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc      <= '0;
         m_fetched <= 1'b0;
         m_halt    <= 1'b0;
         m_warm    <= 1'b0;
         m_instr   <= '0;
         m_count   <= '0;
      end else if (!m_halt) begin
         if (m_fetched) begin
            if (!stall) begin
               if (m_count != 16'hFFFF) m_count <= m_count + 16'd1;
               m_fetched <= 1'b0;
               if (m_instr[15:12] == 4'hF) m_halt <= 1'b1;
               else if (branchTaken)       m_pc   <= branchTarget;
               else                        m_pc   <= m_pc + 8'd1;
            end
         end else if (m_warm && bus.imemAck) begin
            m_fetched <= 1'b1;
            m_instr   <= mem[m_pc];
         end
         m_warm <= 1'b1;
      end
   end

   always @(negedge clk) begin
      chk("cyc_req",     bus.imemReq, !m_halt && !m_fetched && m_warm);
      chk("cyc_addr",    bus.imemAddr, m_pc);
      chk("cyc_pc",      PC, m_pc);
      chk("cyc_valid",   instrValid, m_fetched && !m_halt);
      chk("cyc_halted",  halted, m_halt);
      chk("cyc_opcode",  Opcode, m_instr[15:12]);
      chk("cyc_operand", Operand, m_instr[11:0]);
`ifdef IFETCH_PERF_EN
      chk("cyc_count",   instrCount, m_count);
`else
      chk("cyc_count",   instrCount, 16'h0000);
`endif
   end

   // Memory responder: acks each request after a configurable delay, plus stray acks when idle.
   initial begin : responder
      int  cnt;
      bit  prev;
      cnt = 0;
      prev = 1'b0;
      bus.imemAck  = 1'b0;
      bus.imemData = '0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.imemReq === 1'b1) begin
            if (!prev) cnt = (ack_delay_cfg < 0) ? int'($urandom_range(0, 3)) : ack_delay_cfg;
            if (cnt == 0) begin
               bus.imemAck  = 1'b1;
               bus.imemData = mem[bus.imemAddr];
            end else begin
               bus.imemAck  = 1'b0;
               bus.imemData = 16'($urandom);
               cnt--;
            end
            prev = 1'b1;
         end else begin
            prev = 1'b0;
            bus.imemAck  = spur_en && ($urandom_range(0, 9) == 0);
            bus.imemData = 16'($urandom);
         end
      end
   end

   initial begin : main
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom) & 16'h7FFF;
      mem[8'h00] = 16'h1234;
      mem[8'h01] = 16'h5678;
      mem[8'h40] = 16'h2ABC;
      mem[8'hFF] = 16'h3001;
      mem[8'h80] = 16'hF000;

      #1 rst_n = 1'b0;
      repeat (2) tick();
      chk("rst_req",     bus.imemReq, 1'b0);
      chk("rst_valid",   instrValid, 1'b0);
      chk("rst_halted",  halted, 1'b0);
      chk("rst_pc",      PC, 8'h00);
      chk("rst_opcode",  Opcode, 4'h0);
      chk("rst_count",   instrCount, 16'h0000);

      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      chk("first_req",   bus.imemReq, 1'b1);
      chk("first_valid", instrValid, 1'b0);
      tick();
      chk("t1_valid",    instrValid, 1'b1);
      chk("t1_opcode",   Opcode, 4'h1);
      chk("t1_operand",  Operand, 12'h234);
      chk("t1_req_low",  bus.imemReq, 1'b0);

      stall = 1'b1;
      ack_delay_cfg = 3;
      repeat (4) begin
         tick();
         chk("stall_valid",   instrValid, 1'b1);
         chk("stall_pc",      PC, 8'h00);
         chk("stall_operand", Operand, 12'h234);
      end
      stall = 1'b0;
      tick();
      chk("consume_pc",    PC, 8'h01);
      chk("consume_valid", instrValid, 1'b0);
      repeat (3) begin
         tick();
         chk("dly_req",   bus.imemReq, 1'b1);
         chk("dly_addr",  bus.imemAddr, 8'h01);
         chk("dly_valid", instrValid, 1'b0);
      end
      tick();
      chk("dly_valid_after", instrValid, 1'b1);
      chk("dly_opcode",      Opcode, 4'h5);
      ack_delay_cfg = 0;

      branchTaken = 1'b1; branchTarget = 8'h40;
      tick();
      branchTaken = 1'b0;
      chk("br_addr", bus.imemAddr, 8'h40);
      wait_valid("br_fetch", 10);
      chk("br_opcode", Opcode, 4'h2);

      branchTaken = 1'b1; branchTarget = 8'hFF;
      tick();
      branchTaken = 1'b0;
      wait_valid("ff_fetch", 10);
      chk("ff_opcode", Opcode, 4'h3);
      tick();
      chk("wrap_addr", bus.imemAddr, 8'h00);

      wait_valid("re_fetch", 10);
      branchTaken = 1'b1; branchTarget = 8'h80;
      tick();
      chk("halt_addr", bus.imemAddr, 8'h80);
      wait_valid("halt_fetch", 10);
      chk("halt_opcode", Opcode, 4'hF);
      branchTarget = 8'h22;
      tick();
      branchTaken = 1'b0;
      chk("halt_flag", halted, 1'b1);
      chk("halt_pc",   PC, 8'h80);
      repeat (5) tick();
      chk("halt_hold_req",   bus.imemReq, 1'b0);
      chk("halt_hold_valid", instrValid, 1'b0);
`ifdef IFETCH_PERF_EN
      chk("perf_count", instrCount, 16'd6);
`else
      chk("perf_count", instrCount, 16'd0);
`endif

      @(posedge clk);
      #3 rst_n = 1'b0;
      tick();
      chk("rst2_pc",     PC, 8'h00);
      chk("rst2_halted", halted, 1'b0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      wait_valid("resume_fetch", 10);
      chk("resume_opcode", Opcode, 4'h1);

      ack_delay_cfg = -1;
      spur_en = 1'b1;
      for (int ep = 0; ep < 10; ep++) begin
         @(posedge clk);
         #3 rst_n = 1'b0;
         for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
         tick();
         #2 rst_n = 1'b1;
         for (int c = 0; c < 400; c++) begin
            tick();
            stall        = ($urandom_range(0, 99) < 30);
            branchTaken  = ($urandom_range(0, 99) < 20);
            branchTarget = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            if ((ep % 3 == 1) && (c == 150)) begin
               #2 rst_n = 1'b0;
               tick();
               #2 rst_n = 1'b1;
            end
         end
      end

      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
